// File: rtl/hc_sr04_scan_scheduler.sv
// hc_sr04_scan_scheduler
//   Round-robin scheduler for N HC-SR04 ultrasonic rangers that share one
//   echo-measurement datapath. Each slot triggers one sensor, waits for its
//   echo, converts the echo width to centimetres (saturating at MAX_CM), and
//   then pads the slot so consecutive trigger rising edges are PERIOD_US apart.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   enable         level; high keeps scanning (sampled in IDLE and at slot end)
//   echo_in        raw asynchronous echo lines, one per sensor
//   trig_out       one-hot trigger pulses, at most one bit high
//   busy           high whenever a slot is in progress
//   result_valid   one-cycle strobe; result_* fields valid
//   result_sensor  sensor index of the latest result
//   result_cm      distance in cm (MAX_CM on timeout)
//   result_timeout 1 = no echo or echo over range

module hc_sr04_scan_scheduler #(
    parameter int unsigned N_SENSORS    = 4,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned CYC_PER_US   = 50,
    parameter int unsigned TRIG_US      = 10,
    parameter int unsigned ECHO_WAIT_US = 1000,
    parameter int unsigned CYC_PER_CM   = 2900,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned CM_W         = 9,
    parameter int unsigned PERIOD_US    = 60000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo_in,
    output logic [N_SENSORS-1:0] trig_out,
    output logic                 busy,
    output logic                 result_valid,
    output logic [IDX_W-1:0]     result_sensor,
    output logic [CM_W-1:0]      result_cm,
    output logic                 result_timeout
);

    localparam int unsigned TRIG_CYC   = TRIG_US * CYC_PER_US;
    localparam int unsigned WAIT_CYC   = ECHO_WAIT_US * CYC_PER_US;
    localparam int unsigned PERIOD_CYC = PERIOD_US * CYC_PER_US;
    localparam int unsigned TMR_MAX    = (TRIG_CYC > WAIT_CYC) ? TRIG_CYC : WAIT_CYC;
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
    localparam int unsigned PER_W      = $clog2(PERIOD_CYC + 1);
    localparam int unsigned CYC_W      = $clog2(CYC_PER_CM + 1);

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYC - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [CYC_W-1:0] CPC_LAST  = CYC_W'(CYC_PER_CM - 1);
    localparam logic [CM_W-1:0]  CM_MAX    = CM_W'(MAX_CM);
    localparam logic [CM_W-1:0]  CM_LAST   = CM_W'(MAX_CM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SENSORS - 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, GAP} state_t;

    state_t                state, state_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [TMR_W-1:0]      tmr, tmr_n;
    logic [PER_W-1:0]      per, per_n;
    logic [CYC_W-1:0]      cyc, cyc_n;
    logic [CM_W-1:0]       cm, cm_n;
    logic [N_SENSORS-1:0]  echo_m, echo_s;
    logic                  echo_cur;
    logic                  emit;
    logic [CM_W-1:0]       emit_cm;
    logic                  emit_to;

    assign echo_cur = echo_s[idx];
    assign busy     = (state != IDLE);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        tmr_n   = tmr;
        per_n   = per + PER_W'(1);
        cyc_n   = cyc;
        cm_n    = cm;
        emit    = 1'b0;
        emit_cm = cm;
        emit_to = 1'b0;
        case (state)
            IDLE: begin
                per_n = per;
                if (enable) begin
                    state_n = TRIG;
                    tmr_n   = '0;
                    per_n   = '0;
                end
            end
            TRIG: begin
                tmr_n = tmr + TMR_W'(1);
                if (tmr == TRIG_LAST) begin
                    state_n = WAIT_ECHO;
                    tmr_n   = '0;
                end
            end
            WAIT_ECHO: begin
                tmr_n = tmr + TMR_W'(1);
                if (echo_cur) begin
                    state_n = MEASURE;
                    cyc_n   = '0;
                    cm_n    = '0;
                end else if (tmr == WAIT_LAST) begin
                    state_n = GAP;
                    emit    = 1'b1;
                    emit_cm = CM_MAX;
                    emit_to = 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_cur) begin
                    state_n = GAP;
                    emit    = 1'b1;
                end else if (cyc == CPC_LAST) begin
                    cyc_n = '0;
                    // The wrap that would take cm to MAX_CM ends the slot at once.
                    if (cm == CM_LAST) begin
                        state_n = GAP;
                        emit    = 1'b1;
                        emit_cm = CM_MAX;
                        emit_to = 1'b1;
                    end else begin
                        cm_n = cm + CM_W'(1);
                    end
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            GAP: begin
                if (per >= PER_LAST) begin
                    idx_n = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    if (enable) begin
                        state_n = TRIG;
                        tmr_n   = '0;
                        per_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            tmr            <= '0;
            per            <= '0;
            cyc            <= '0;
            cm             <= '0;
            echo_m         <= '0;
            echo_s         <= '0;
            trig_out       <= '0;
            result_valid   <= 1'b0;
            result_sensor  <= '0;
            result_cm      <= '0;
            result_timeout <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            tmr          <= tmr_n;
            per          <= per_n;
            cyc          <= cyc_n;
            cm           <= cm_n;
            echo_m       <= echo_in;
            echo_s       <= echo_m;
            // Registered from the next state so the pulse is glitch-free and
            // coincides exactly with the cycles spent in TRIG.
            trig_out     <= (state_n == TRIG) ? (N_SENSORS'(1) << idx_n) : '0;
            result_valid <= emit;
            if (emit) begin
                result_sensor  <= idx;
                result_cm      <= emit_cm;
                result_timeout <= emit_to;
            end
        end
    end

endmodule

// File: tb/tb_hc_sr04_scan_scheduler.sv
// Directed testbench for hc_sr04_scan_scheduler with small timing parameters:
// CYC_PER_US=1, TRIG_US=10, ECHO_WAIT_US=50, CYC_PER_CM=4, MAX_CM=20,
// PERIOD_US=200. Inputs change and outputs are sampled on the falling edge.

module tb_hc_sr04_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] echo_in;
    logic [3:0] trig_out;
    logic       busy;
    logic       result_valid;
    logic [1:0] result_sensor;
    logic [8:0] result_cm;
    logic       result_timeout;

    int total = 0;
    int bad   = 0;
    int now   = 0;

    always #5 clk = ~clk;

    hc_sr04_scan_scheduler #(
        .N_SENSORS    (4),
        .IDX_W        (2),
        .CYC_PER_US   (1),
        .TRIG_US      (10),
        .ECHO_WAIT_US (50),
        .CYC_PER_CM   (4),
        .MAX_CM       (20),
        .CM_W         (9),
        .PERIOD_US    (200)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .echo_in        (echo_in),
        .trig_out       (trig_out),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_sensor  (result_sensor),
        .result_cm      (result_cm),
        .result_timeout (result_timeout)
    );

    task automatic tick();
        @(negedge clk);
        now++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait for the next trigger, return its value, the time it was first
    // seen and how many cycles it stayed high. Returns at the first cycle
    // after the trigger fell.
    task automatic get_slot(output logic [3:0] val, output int rise, output int width);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (trig_out === 4'b0000 && n < 500);
        val   = trig_out;
        rise  = now;
        width = 0;
        if (val !== 4'b0000) begin
            width = 1;
            for (int k = 0; k < 50; k++) begin
                tick();
                if (trig_out === val) width++;
                else break;
            end
        end
    endtask

    task automatic wait_valid(output int t);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (result_valid !== 1'b1 && n < 500);
        t = (result_valid === 1'b1) ? now : -1;
    endtask

    initial begin
        logic [3:0] v;
        int r0, r1, r2, r3, r4, w, tv, t_en, nv, n;

        reset   = 1'b1;
        enable  = 1'b0;
        echo_in = 4'b0000;
        repeat (3) tick();
        check("rst_trig",    trig_out, 0);
        check("rst_busy",    busy, 0);
        check("rst_valid",   result_valid, 0);
        check("rst_sensor",  result_sensor, 0);
        check("rst_cm",      result_cm, 0);
        check("rst_timeout", result_timeout, 0);

        reset = 1'b0;
        repeat (5) tick();
        check("idle_busy", busy, 0);
        check("idle_trig", trig_out, 0);

        // Slot 0: echo high for 42 cycles -> floor(41/4) = 10 cm
        t_en   = now;
        enable = 1'b1;
        get_slot(v, r0, w);
        check("s0_trig",  v, 4'b0001);
        check("s0_lat",   r0 - t_en, 1);
        check("s0_width", w, 10);
        check("s0_busy",  busy, 1);
        echo_in[0] = 1'b1;
        repeat (42) tick();
        echo_in[0] = 1'b0;
        wait_valid(tv);
        check("s0_valid_t", tv - r0, 55);
        check("s0_sensor",  result_sensor, 0);
        check("s0_cm",      result_cm, 10);
        check("s0_to",      result_timeout, 0);
        tick();
        check("s0_strobe_len", result_valid, 0);
        check("s0_hold_cm",    result_cm, 10);

        // Slot 1: no echo -> timeout 50 cycles after trigger end
        get_slot(v, r1, w);
        check("s1_trig",    v, 4'b0010);
        check("s1_spacing", r1 - r0, 200);
        check("s1_width",   w, 10);
        wait_valid(tv);
        check("s1_valid_t", tv - (r1 + 10), 50);
        check("s1_sensor",  result_sensor, 1);
        check("s1_cm",      result_cm, 20);
        check("s1_to",      result_timeout, 1);

        // Slot 2: echo stuck high -> over-range after 80 measured cycles
        echo_in[2] = 1'b1;
        get_slot(v, r2, w);
        check("s2_trig",    v, 4'b0100);
        check("s2_spacing", r2 - r1, 200);
        wait_valid(tv);
        check("s2_valid_t", tv - r2, 91);
        check("s2_sensor",  result_sensor, 2);
        check("s2_cm",      result_cm, 20);
        check("s2_to",      result_timeout, 1);
        repeat (10) tick();
        echo_in[2] = 1'b0;
        nv = 0;
        repeat (60) begin
            tick();
            if (result_valid === 1'b1) nv++;
        end
        check("s2_no_extra", nv, 0);

        // Slot 3: enable dropped mid-measure; 20-cycle echo -> 4 cm
        get_slot(v, r3, w);
        check("s3_trig",    v, 4'b1000);
        check("s3_spacing", r3 - r2, 200);
        echo_in[3] = 1'b1;
        repeat (10) tick();
        enable = 1'b0;
        repeat (10) tick();
        echo_in[3] = 1'b0;
        wait_valid(tv);
        check("s3_valid_t", tv - r3, 33);
        check("s3_sensor",  result_sensor, 3);
        check("s3_cm",      result_cm, 4);
        check("s3_to",      result_timeout, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy === 1'b1 && n < 400);
        check("s3_gap_end", now - r3, 200);
        repeat (20) tick();
        check("disabled_busy", busy, 0);
        check("disabled_trig", trig_out, 0);

        // Re-enable: index wrapped to sensor 0
        t_en   = now;
        enable = 1'b1;
        get_slot(v, r4, w);
        check("re_trig",  v, 4'b0001);
        check("re_lat",   r4 - t_en, 1);
        check("re_width", w, 10);
        wait_valid(tv);
        check("re_valid_t", tv - r4, 60);
        check("re_sensor",  result_sensor, 0);
        check("re_to",      result_timeout, 1);

        // Reset in the middle of sensor 1's trigger pulse
        n = 0;
        do begin
            tick();
            n++;
        end while (trig_out === 4'b0000 && n < 400);
        check("pre_rst_trig", trig_out, 4'b0010);
        check("pre_rst_t",    now - r4, 200);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_trig",    trig_out, 0);
        check("mid_rst_busy",    busy, 0);
        check("mid_rst_valid",   result_valid, 0);
        check("mid_rst_sensor",  result_sensor, 0);
        check("mid_rst_cm",      result_cm, 0);
        check("mid_rst_timeout", result_timeout, 0);
        repeat (3) tick();
        check("mid_rst_noresult", result_valid, 0);
        reset = 1'b0;
        t_en  = now;
        get_slot(v, r0, w);
        check("post_rst_trig", v, 4'b0001);
        check("post_rst_lat",  r0 - t_en, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
